multicycle_controller: RTL

- Multicycle successor to the single-cycle ARM controller.
- One FSM sequences each instruction over 3-5 cycles through shared memory, the ALU and the register file. It drives all datapath selects and enables.
- Holds the NZCV flag register and the condition-evaluation logic internally.
- ALU-control width is parametrised, so wider builds decode extra data-processing commands.

---
 rtl/multicycle_controller.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM-based control unit for the multicycle ARM datapath.
// Sequences each instruction over 3-5 cycles, decodes the ALU command, holds the
// NZCV flag register and evaluates the condition field.
// Optional feature: define MEM_READY_EN to add a MemReady handshake that stalls
// FETCH, MEMRD and MEMWR until memory accepts the access.
module multicycle_controller #(
    parameter int ALUCTRL_W = 2,
    parameter int FLAGS_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          Instr,
    input  logic [FLAGS_W-1:0]   ALUFlags,
`ifdef MEM_READY_EN
    input  logic                 MemReady,
`endif
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    if (FLAGS_W != 4) begin : gFlagsWidthCheck
        $error("multicycle_controller: FLAGS_W must be 4");
    end
    if (ALUCTRL_W != 2 && ALUCTRL_W != 3) begin : gAluCtrlWidthCheck
        $error("multicycle_controller: ALUCTRL_W must be 2 or 3");
    end

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    state_e state_q, state_d;
    logic [3:0] flags_q;
    logic       condExR_q;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd, rd, cond;
    logic       memReady;
    logic       condEx;
    logic [ALUCTRL_W-1:0] aluCmd;
    logic       cmdValid, isArith, isCmp, sBit;
    logic [1:0] flagW;
    logic       pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw;
    logic       unusedInstr;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign cmd   = funct[4:1];
    assign rd    = Instr[15:12];
    assign cond  = Instr[31:28];
    assign unusedInstr = ^{Instr[19:16], Instr[11:0]};

`ifdef MEM_READY_EN
    assign memReady = MemReady;
`else
    assign memReady = 1'b1;
`endif

    // Data-processing command decode: ALU operation, legality, and flag-write class
    always_comb begin
        aluCmd   = ALU_ADD;
        cmdValid = 1'b0;
        isArith  = 1'b0;
        isCmp    = 1'b0;
        case (cmd)
            4'b0100: begin aluCmd = ALU_ADD; cmdValid = 1'b1; isArith = 1'b1; end
            4'b0010: begin aluCmd = ALU_SUB; cmdValid = 1'b1; isArith = 1'b1; end
            4'b0000: begin aluCmd = ALU_AND; cmdValid = 1'b1; end
            4'b1100: begin aluCmd = ALU_ORR; cmdValid = 1'b1; end
            4'b0001: begin
                if (ALUCTRL_W == 3) begin
                    aluCmd   = ALU_EOR;
                    cmdValid = 1'b1;
                end
            end
            4'b1010: begin
                if (ALUCTRL_W == 3) begin
                    aluCmd  = ALU_SUB;
                    isArith = 1'b1;
                    isCmp   = 1'b1;
                end
            end
            default: begin end
        endcase
        sBit     = funct[0] | isCmp;
        flagW[1] = sBit;
        flagW[0] = sBit & isArith;
    end

    // Condition evaluation against the stored {N,Z,C,V}; 1110 and 1111 both mean always
    always_comb begin
        condEx = 1'b1;
        case (cond)
            4'b0000: condEx = flags_q[2];
            4'b0001: condEx = ~flags_q[2];
            4'b0010: condEx = flags_q[1];
            4'b0011: condEx = ~flags_q[1];
            4'b0100: condEx = flags_q[3];
            4'b0101: condEx = ~flags_q[3];
            4'b0110: condEx = flags_q[0];
            4'b0111: condEx = ~flags_q[0];
            4'b1000: condEx = flags_q[1] & ~flags_q[2];
            4'b1001: condEx = ~flags_q[1] | flags_q[2];
            4'b1010: condEx = (flags_q[3] == flags_q[0]);
            4'b1011: condEx = (flags_q[3] != flags_q[0]);
            4'b1100: condEx = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: condEx = flags_q[2] | (flags_q[3] != flags_q[0]);
            default: condEx = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Condition result is captured once, at the end of DECODE, and gates all later writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     condExR_q <= 1'b0;
        else if (state_q == S_DECODE) condExR_q <= condEx;
    end

    // Flag register: NZ and CV halves update independently at the end of execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (state_q == S_EXECUTER || state_q == S_EXECUTEI) begin
            if (flagW[1] & condExR_q) flags_q[3:2] <= ALUFlags[3:2];
            if (flagW[0] & condExR_q) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = memReady ? S_FETCH : S_MEMWR;
            S_EXECUTER,
            S_EXECUTEI: state_d = isCmp ? S_FETCH : S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath selects and raw enables
    always_comb begin
        pcWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                irWriteRaw = memReady;
                pcWriteRaw = memReady;
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                memWriteRaw = condExR_q;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                if (rd == 4'hF) pcWriteRaw  = condExR_q;
                else            regWriteRaw = condExR_q;
            end
            S_EXECUTER: ALUControl = aluCmd;
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = aluCmd;
            end
            S_ALUWB: begin
                if (rd == 4'hF) pcWriteRaw  = condExR_q & cmdValid;
                else            regWriteRaw = condExR_q & cmdValid;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pcWriteRaw = condExR_q;
            end
            default: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
        endcase
    end

    // Architectural enables are suppressed for as long as reset is held
    assign PCWrite  = pcWriteRaw  & ~rst;
    assign MemWrite = memWriteRaw & ~rst;
    assign IRWrite  = irWriteRaw  & ~rst;
    assign RegWrite = regWriteRaw & ~rst;
    assign ImmSrc   = op;
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign State    = state_q;

endmodule
